// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan driver with frame-aligned page double buffering
// and per-digit blinking. Outputs are registered from next-state values.
module seg_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int DIV       = 1000,
   parameter int BLINK_DIV = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   page_data,
   input  logic                  page_load,
   input  logic                  blink_en,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic [DIGITS-1:0]     an,
   output logic [3:0]            digit_val,
   output logic                  blank,
   output logic                  frame_done
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [PW-1:0]       P_LAST     = PW'(DIV - 1);
   localparam logic [IW-1:0]       I_LAST     = IW'(DIGITS - 1);
   localparam logic [FW-1:0]       F_LAST     = FW'(BLINK_DIV - 1);
   localparam logic [4*DIGITS-1:0] BLANK_PAGE = {DIGITS{4'hF}};

   logic [PW-1:0]       p, p_n;
   logic [IW-1:0]       idx, idx_n;
   logic [FW-1:0]       fcnt, fcnt_n;
   logic                ph, ph_n;
   logic [4*DIGITS-1:0] active, active_n;
   logic [4*DIGITS-1:0] pending, pending_n;
   logic                pend_v, pend_v_n;

   logic                tick;
   logic                boundary;
   logic [3:0]          nibble;
   logic                suppress;
   logic [DIGITS-1:0]   an_n;

   always_comb begin
      tick      = (p == P_LAST);
      boundary  = tick && (idx == I_LAST);

      p_n       = tick ? '0 : p + PW'(1);
      idx_n     = idx;
      if (tick) begin
         idx_n = (idx == I_LAST) ? '0 : idx + IW'(1);
      end

      fcnt_n    = fcnt;
      ph_n      = ph;
      active_n  = active;
      pending_n = pending;
      pend_v_n  = pend_v;

      if (page_load) begin
         pending_n = page_data;
         pend_v_n  = 1'b1;
      end

      if (boundary) begin
         // A load landing on the boundary itself bypasses the pending buffer.
         if (page_load) begin
            active_n = page_data;
         end else if (pend_v) begin
            active_n = pending;
         end
         pend_v_n = 1'b0;

         if (fcnt == F_LAST) begin
            fcnt_n = '0;
            ph_n   = ~ph;
         end else begin
            fcnt_n = fcnt + FW'(1);
         end
      end

      nibble   = active_n[{idx_n, 2'b00} +: 4];
      suppress = (nibble == 4'hF) || (blink_en && blink_mask[idx_n] && ph_n);

      an_n = '1;
      for (int i = 0; i < DIGITS; i++) begin
         an_n[i] = (idx_n != IW'(i));
      end
      if (suppress) begin
         an_n = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p          <= '0;
         idx        <= '0;
         fcnt       <= '0;
         ph         <= 1'b0;
         active     <= BLANK_PAGE;
         pending    <= BLANK_PAGE;
         pend_v     <= 1'b0;
         an         <= '1;
         digit_val  <= 4'h0;
         blank      <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         p          <= p_n;
         idx        <= idx_n;
         fcnt       <= fcnt_n;
         ph         <= ph_n;
         active     <= active_n;
         pending    <= pending_n;
         pend_v     <= pend_v_n;
         an         <= an_n;
         digit_val  <= nibble;
         blank      <= suppress;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic against a
// timeline model that derives slot, frame and blink phase from elapsed cycles.
module tb_seg_scan_ctrl;

   localparam int DIGITS    = 4;
   localparam int DIV       = 4;
   localparam int BLINK_DIV = 2;
   localparam int FRAME     = DIGITS * DIV;

   logic        clk;
   logic        reset;
   logic [15:0] page_data;
   logic        page_load;
   logic        blink_en;
   logic [3:0]  blink_mask;
   logic [3:0]  an;
   logic [3:0]  digit_val;
   logic        blank;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   // model state
   int          t;
   logic [15:0] m_active, m_pending;
   logic        m_pv;
   logic [3:0]  m_an, m_dv;
   logic        m_blank, m_fd;

   seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLINK_DIV(BLINK_DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .page_data  (page_data),
      .page_load  (page_load),
      .blink_en   (blink_en),
      .blink_mask (blink_mask),
      .an         (an),
      .digit_val  (digit_val),
      .blank      (blank),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock; the model consumes the same inputs the DUT sampled.
   task automatic step();
      int         slot;
      int         phase;
      logic [3:0] nib;
      logic       supp;
      logic       bnd;
      @(posedge clk);
      if (reset) begin
         t         = 0;
         m_active  = 16'hFFFF;
         m_pending = 16'hFFFF;
         m_pv      = 1'b0;
         m_an      = 4'hF;
         m_dv      = 4'h0;
         m_blank   = 1'b1;
         m_fd      = 1'b0;
      end else begin
         t   = t + 1;
         bnd = ((t % FRAME) == 0);
         if (bnd) begin
            if (page_load) m_active = page_data;
            else if (m_pv) m_active = m_pending;
            m_pv = 1'b0;
         end else if (page_load) begin
            m_pending = page_data;
            m_pv      = 1'b1;
         end
         slot    = (t / DIV) % DIGITS;
         phase   = ((t / FRAME) / BLINK_DIV) % 2;
         nib     = m_active[slot*4 +: 4];
         supp    = (nib == 4'hF) || (blink_en && blink_mask[slot] && (phase == 1));
         m_an    = supp ? 4'hF : ~(4'b0001 << slot);
         m_blank = supp;
         m_dv    = nib;
         m_fd    = bnd;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({an, blank, frame_done, digit_val} !== {4'hF, 1'b1, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_hold: an=%b blank=%b fd=%b dv=%h, want an=1111 blank=1 fd=0 dv=0",
                     an, blank, frame_done, digit_val);
         end
      end
      reset = 1'b0;
      for (int i = 1; i <= FRAME; i++) begin
         step();
         checks++;
         if ({an, blank, digit_val, frame_done} !== {m_an, m_blank, m_dv, m_fd}) begin
            errors++;
            $display("FAIL reset_frame t=%0d: an=%b blank=%b dv=%h fd=%b, want %b %b %h %b",
                     t, an, blank, digit_val, frame_done, m_an, m_blank, m_dv, m_fd);
         end
         checks++;
         if (frame_done !== (i == FRAME)) begin
            errors++;
            $display("FAIL first_frame_done cycle=%0d: fd=%b, want %b", i, frame_done, (i == FRAME));
         end
      end
   endtask

   task automatic test_load_commit();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         page_load = (c == 2);
         page_data = 16'h1234;
         step();
         page_load = 1'b0;
         checks++;
         if ({an, blank, digit_val, frame_done} !== {m_an, m_blank, m_dv, m_fd}) begin
            errors++;
            $display("FAIL load_commit t=%0d: an=%b blank=%b dv=%h fd=%b, want %b %b %h %b",
                     t, an, blank, digit_val, frame_done, m_an, m_blank, m_dv, m_fd);
         end
         if (t == 15 || t == 16 || t == 20 || t == 28) begin
            checks++;
            if ((t == 15 && blank !== 1'b1) ||
                (t == 16 && {an, digit_val} !== {4'b1110, 4'h4}) ||
                (t == 20 && {an, digit_val} !== {4'b1101, 4'h3}) ||
                (t == 28 && {an, digit_val} !== {4'b0111, 4'h1})) begin
               errors++;
               $display("FAIL commit_point t=%0d: an=%b dv=%h blank=%b", t, an, digit_val, blank);
            end
         end
      end
   endtask

   task automatic test_last_load_wins();
      logic [15:0] old_pg;
      logic        seen;
      int          slot;
      old_pg = 16'h5678;
      seen   = 1'b0;
      for (int c = 0; c < 40; c++) begin
         page_load = (c == 1) || (c == 3);
         page_data = (c == 1) ? 16'h5678 : 16'h9ABC;
         step();
         page_load = 1'b0;
         slot = (t / DIV) % DIGITS;
         if (blank === 1'b0 && digit_val === old_pg[slot*4 +: 4]) seen = 1'b1;
         checks++;
         if ({an, blank, digit_val, frame_done} !== {m_an, m_blank, m_dv, m_fd}) begin
            errors++;
            $display("FAIL last_load t=%0d: an=%b blank=%b dv=%h fd=%b, want %b %b %h %b",
                     t, an, blank, digit_val, frame_done, m_an, m_blank, m_dv, m_fd);
         end
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL last_load_stale: stale page shown=%b, want 0", seen);
      end
   endtask

   task automatic test_boundary_load();
      for (int k = 0; k < FRAME && (t % FRAME) != FRAME - 1; k++) step();
      checks++;
      if ((t % FRAME) != FRAME - 1) begin
         errors++;
         $display("FAIL boundary_align: t=%0d, want t mod %0d = %0d", t, FRAME, FRAME - 1);
      end
      page_load = 1'b1;
      page_data = 16'h4321;
      step();
      page_load = 1'b0;
      checks++;
      if ({an, digit_val, frame_done, dut.pend_v} !== {4'b1110, 4'h1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL boundary_load: an=%b dv=%h fd=%b pend_v=%b, want 1110 1 1 0",
                  an, digit_val, frame_done, dut.pend_v);
      end
      for (int c = 0; c < FRAME; c++) begin
         step();
         checks++;
         if ({an, blank, digit_val, frame_done} !== {m_an, m_blank, m_dv, m_fd}) begin
            errors++;
            $display("FAIL boundary_after t=%0d: an=%b blank=%b dv=%h fd=%b, want %b %b %h %b",
                     t, an, blank, digit_val, frame_done, m_an, m_blank, m_dv, m_fd);
         end
      end
   endtask

   task automatic test_blink();
      int n_d0, n_d2, n_blank;
      n_d0 = 0; n_d2 = 0; n_blank = 0;
      blink_en   = 1'b1;
      blink_mask = 4'b0001;
      page_load  = 1'b1;
      page_data  = 16'hF0F1;
      step();
      page_load = 1'b0;
      for (int k = 0; k < FRAME + 1 && !m_fd; k++) step();
      for (int c = 0; c < 8 * FRAME; c++) begin
         if (c != 0) step();
         checks++;
         if ({an, blank, digit_val, frame_done} !== {m_an, m_blank, m_dv, m_fd}) begin
            errors++;
            $display("FAIL blink t=%0d: an=%b blank=%b dv=%h fd=%b, want %b %b %h %b",
                     t, an, blank, digit_val, frame_done, m_an, m_blank, m_dv, m_fd);
         end
         if (an === 4'b1110 && digit_val === 4'h1) n_d0++;
         if (an === 4'b1011 && digit_val === 4'h0) n_d2++;
         if (an === 4'b1111 && blank === 1'b1) n_blank++;
      end
      checks++;
      if (n_d0 != 16 || n_d2 != 32 || n_blank != 80) begin
         errors++;
         $display("FAIL blink_counts: d0=%0d d2=%0d blank=%0d, want 16 32 80", n_d0, n_d2, n_blank);
      end
      blink_en   = 1'b0;
      blink_mask = 4'b0000;
   endtask

   task automatic test_reset_mid_frame();
      logic shown;
      shown = 1'b0;
      for (int k = 0; k < FRAME && ((t / DIV) % DIGITS) != 1; k++) step();
      page_load = 1'b1;
      page_data = 16'h7777;
      step();
      page_load = 1'b0;
      for (int k = 0; k < FRAME && ((t / DIV) % DIGITS) != 2; k++) step();
      checks++;
      if ({dut.pend_v, dut.idx} !== {1'b1, 2'd2}) begin
         errors++;
         $display("FAIL midreset_setup: pend_v=%b idx=%0d, want 1 2", dut.pend_v, dut.idx);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({an, blank, digit_val, dut.idx} !== {4'hF, 1'b1, 4'h0, 2'd0}) begin
         errors++;
         $display("FAIL midreset: an=%b blank=%b dv=%h idx=%0d, want 1111 1 0 0",
                  an, blank, digit_val, dut.idx);
      end
      for (int c = 0; c < 3 * FRAME; c++) begin
         step();
         if (blank === 1'b0 && digit_val === 4'h7) shown = 1'b1;
         checks++;
         if ({an, blank, digit_val, frame_done} !== {m_an, m_blank, m_dv, m_fd}) begin
            errors++;
            $display("FAIL midreset_after t=%0d: an=%b blank=%b dv=%h fd=%b, want %b %b %h %b",
                     t, an, blank, digit_val, frame_done, m_an, m_blank, m_dv, m_fd);
         end
      end
      checks++;
      if (shown !== 1'b0) begin
         errors++;
         $display("FAIL midreset_pending: discarded page shown=%b, want 0", shown);
      end
   endtask

   task automatic test_random();
      logic [15:0] d;
      for (int c = 0; c < 1200; c++) begin
         d = 16'($urandom);
         for (int n = 0; n < 4; n++) if ($urandom_range(0, 3) == 0) d[n*4 +: 4] = 4'hF;
         page_data = d;
         page_load = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 19) == 0) blink_en = ~blink_en;
         if ($urandom_range(0, 9) == 0) blink_mask = 4'($urandom);
         reset = ($urandom_range(0, 299) == 0);
         step();
         checks++;
         if ({an, blank, digit_val, frame_done} !== {m_an, m_blank, m_dv, m_fd}) begin
            errors++;
            $display("FAIL random t=%0d: an=%b blank=%b dv=%h fd=%b, want %b %b %h %b",
                     t, an, blank, digit_val, frame_done, m_an, m_blank, m_dv, m_fd);
         end
      end
      reset     = 1'b0;
      page_load = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      page_load  = 1'b0;
      page_data  = 16'h0000;
      blink_en   = 1'b0;
      blink_mask = 4'b0000;
      t          = 0;
      test_reset();
      test_load_commit();
      test_last_load_wins();
      test_boundary_load();
      test_blink();
      test_reset_mid_frame();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
